// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - shared types and constants for the flash write/verify exerciser
package flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_RD_INIT,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_CHECK,
        ST_FINISH
    } state_t;

    localparam logic [1:0] MODE_WR_VERIFY = 2'b00;
    localparam logic [1:0] MODE_VERIFY    = 2'b01;
    localparam logic [1:0] MODE_WRITE     = 2'b10;
    localparam logic [1:0] MODE_RSVD      = 2'b11;

    // Right-shifting Galois feedback masks for maximal-length sequences
    function automatic logic [63:0] lfsr_taps(input int width);
        case (width)
            8:       return 64'h0000_0000_0000_00B8;
            16:      return 64'h0000_0000_0000_B400;
            24:      return 64'h0000_0000_00E1_0000;
            32:      return 64'h0000_0000_A300_0000;
            64:      return 64'hD800_0000_0000_0000;
            default: return 64'h0000_0000_A300_0000;
        endcase
    endfunction

    function automatic int word_bytes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/flash_exerciser_pattern_gen.sv
// rtl/flash_exerciser_pattern_gen.sv - Galois LFSR pattern source with load and zero-seed fixup
module flash_pattern_gen
    import flash_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              advance,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] pattern,
    output logic [DATA_W-1:0] pattern_next
);

    localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));

    // pattern_next lets the caller register the value the LFSR holds after this edge
    always_comb begin
        pattern_next = pattern;
        if (load) begin
            pattern_next = (seed == '0) ? '1 : seed;
        end else if (advance) begin
            pattern_next = (pattern >> 1) ^ (pattern[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pattern <= '1;
        end else begin
            pattern <= pattern_next;
        end
    end

endmodule

// File: rtl/flash_exerciser.sv
// rtl/flash_exerciser.sv - write/verify traffic sequencer for the SPI flash controller
module flash_exerciser
    import flash_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 22,
    parameter int TIMEOUT_CYC = 2**20,
    parameter int ERR_W       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              halt_on_err,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    input  logic [DATA_W-1:0] seed,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_write,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_wdata,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic [CNT_W-1:0]  word_idx
);

    localparam int WB    = word_bytes(DATA_W);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    state_t            state;
    logic [1:0]        mode_q;
    logic              halt_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  num_q;
    logic [DATA_W-1:0] seed_q;
    logic [DATA_W-1:0] rdata_q;
    logic [TMR_W-1:0]  timer;
    logic              fail_seen;

    logic [DATA_W-1:0] pattern;
    logic [DATA_W-1:0] pattern_next;
    logic              pat_load;
    logic              pat_adv;
    logic [DATA_W-1:0] pat_seed;

    logic [ADDR_W-1:0] base_al;
    logic              last_word;
    logic              expired;
    logic              mismatch;

    assign base_al   = base_addr & ~ADDR_W'(WB - 1);
    assign last_word = (word_idx + CNT_W'(1)) == num_q;
    assign expired   = timer == TMR_W'(TIMEOUT_CYC - 1);
    assign mismatch  = rdata_q != pattern;

    assign pat_load = (state == ST_IDLE && start) || state == ST_RD_INIT;
    assign pat_adv  = (state == ST_WR_WAIT && rsp_valid) || state == ST_CHECK;
    assign pat_seed = (state == ST_IDLE) ? seed : seed_q;

    flash_pattern_gen #(.DATA_W(DATA_W)) u_pattern (
        .clk          (clk),
        .reset_n      (reset_n),
        .load         (pat_load),
        .advance      (pat_adv),
        .seed         (pat_seed),
        .pattern      (pattern),
        .pattern_next (pattern_next)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            mode_q          <= '0;
            halt_q          <= 1'b0;
            base_q          <= '0;
            num_q           <= '0;
            seed_q          <= '0;
            rdata_q         <= '0;
            timer           <= '0;
            fail_seen       <= 1'b0;
            cmd_valid       <= 1'b0;
            cmd_write       <= 1'b0;
            cmd_addr        <= '0;
            cmd_wdata       <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            timeout         <= 1'b0;
            err_count       <= '0;
            first_fail_addr <= '0;
            word_idx        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        timeout         <= 1'b0;
                        err_count       <= '0;
                        first_fail_addr <= '0;
                        word_idx        <= '0;
                        fail_seen       <= 1'b0;
                        mode_q          <= mode;
                        halt_q          <= halt_on_err;
                        base_q          <= base_al;
                        num_q           <= num_words;
                        seed_q          <= seed;
                        cmd_addr        <= base_al;
                        if (num_words == '0) begin
                            state <= ST_FINISH;
                        end else if (mode == MODE_WR_VERIFY || mode == MODE_WRITE) begin
                            state     <= ST_WR_REQ;
                            cmd_valid <= 1'b1;
                            cmd_write <= 1'b1;
                            cmd_wdata <= pattern_next;
                        end else begin
                            state <= ST_RD_INIT;
                        end
                    end
                end
                ST_WR_REQ, ST_RD_REQ: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        timer     <= '0;
                        state     <= (state == ST_WR_REQ) ? ST_WR_WAIT : ST_RD_WAIT;
                    end
                end
                ST_WR_WAIT, ST_RD_WAIT: begin
                    if (rsp_valid) begin
                        if (state == ST_RD_WAIT) begin
                            rdata_q <= rsp_rdata;
                            state   <= ST_CHECK;
                        end else begin
                            word_idx <= word_idx + CNT_W'(1);
                            if (last_word) begin
                                state <= (mode_q == MODE_WR_VERIFY) ? ST_RD_INIT : ST_FINISH;
                            end else begin
                                state     <= ST_WR_REQ;
                                cmd_valid <= 1'b1;
                                cmd_addr  <= cmd_addr + ADDR_W'(WB);
                                cmd_wdata <= pattern_next;
                            end
                        end
                    end else if (expired) begin
                        timeout <= 1'b1;
                        state   <= ST_FINISH;
                        if (!fail_seen) begin
                            first_fail_addr <= cmd_addr;
                            fail_seen       <= 1'b1;
                        end
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_RD_INIT: begin
                    word_idx  <= '0;
                    cmd_addr  <= base_q;
                    cmd_valid <= 1'b1;
                    cmd_write <= 1'b0;
                    state     <= ST_RD_REQ;
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_count != '1) begin
                            err_count <= err_count + ERR_W'(1);
                        end
                        if (!fail_seen) begin
                            first_fail_addr <= cmd_addr;
                            fail_seen       <= 1'b1;
                        end
                    end
                    word_idx <= word_idx + CNT_W'(1);
                    if ((halt_q && mismatch) || last_word) begin
                        state <= ST_FINISH;
                    end else begin
                        state     <= ST_RD_REQ;
                        cmd_valid <= 1'b1;
                        cmd_addr  <= cmd_addr + ADDR_W'(WB);
                    end
                end
                ST_FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_count == '0) && !timeout;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
